// File: rtl/gmii_receiver.sv
// gmii_receiver: hunts preamble/SFD on a GMII receive port, checks the FCS,
// buffers one frame and replays its body (FCS stripped) on a srdy/drdy stream
// with end-of-packet status and length.
module gmii_receiver #(
  parameter int MAX_LEN = 2048,
  parameter int MIN_LEN = 64
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic        p_srdy,
  input  logic        p_drdy,
  output logic [7:0]  p_data,
  output logic        p_eop,
  output logic [1:0]  p_status,
  output logic [15:0] p_len,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    s_idle, s_preamble, s_data, s_drain, s_drop
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            rx_dv_prev_q;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   last_q, last_d;
  logic            p_srdy_q, p_srdy_d;
  logic            p_eop_q, p_eop_d;
  logic [1:0]      p_status_q, p_status_d;
  logic [15:0]     p_len_q, p_len_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [7:0]      p_data_q;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            frame_inc;
  logic            drop_inc;

  logic [7:0]      frame_mem [MAX_LEN];

  // Reflected CRC-32, one byte per call, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Next-state logic: frame hunt, buffer write, drain sequencing and counters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    idx_d      = idx_q;
    last_d     = last_q;
    p_srdy_d   = p_srdy_q;
    p_eop_d    = p_eop_q;
    p_status_d = p_status_q;
    p_len_d    = p_len_q;
    wr_en      = 1'b0;
    wr_addr    = cnt_q[AW-1:0];
    rd_en      = 1'b0;
    rd_addr    = idx_q;
    frame_inc  = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      s_idle, s_preamble: begin
        if (!rx_dv) begin
          if (state_q == s_preamble) begin
            state_d  = s_idle;
            drop_inc = 1'b1;
          end
        end else if (rxd == 8'h55) begin
          state_d = s_preamble;
        end else if (rxd == 8'hD5) begin
          state_d = s_data;
          cnt_d   = '0;
          crc_d   = 32'hFFFFFFFF;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d  = s_drop;
          drop_inc = 1'b1;
        end
      end
      s_data: begin
        if (rx_dv) begin
          crc_d = crc_byte(crc_q, rxd);
          if (rx_er) err_d = 1'b1;
          if (cnt_q == CW'(MAX_LEN)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q <= CW'(4)) begin
          state_d  = s_idle;
          drop_inc = 1'b1;
        end else begin
          // Prefetch byte 0 so it is on p_data in the first drain cycle.
          state_d  = s_drain;
          rd_en    = 1'b1;
          rd_addr  = '0;
          idx_d    = AW'(1);
          last_d   = AW'(cnt_q - CW'(5));
          p_srdy_d = 1'b1;
          p_eop_d  = (cnt_q == CW'(5));
          p_len_d  = 16'(cnt_q - CW'(4));
          if (ovf_q || err_q)              p_status_d = 2'd3;
          else if (cnt_q < CW'(MIN_LEN))   p_status_d = 2'd2;
          else if (crc_q != CRC_RESIDUE)   p_status_d = 2'd1;
          else                             p_status_d = 2'd0;
        end
      end
      s_drain: begin
        // A frame starting while draining is lost; count it once on its rising rx_dv.
        if (rx_dv && !rx_dv_prev_q) drop_inc = 1'b1;
        if (p_drdy) begin
          if (p_eop_q) begin
            p_srdy_d  = 1'b0;
            p_eop_d   = 1'b0;
            frame_inc = 1'b1;
            state_d   = rx_dv ? s_drop : s_idle;
          end else begin
            rd_en   = 1'b1;
            rd_addr = idx_q;
            idx_d   = idx_q + AW'(1);
            p_eop_d = (idx_q == last_q);
          end
        end
      end
      s_drop: begin
        if (!rx_dv) state_d = s_idle;
      end
      default: state_d = s_idle;
    endcase

    frame_cnt_d = frame_cnt_q;
    if (frame_inc && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // State and output registers.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q      <= s_idle;
      cnt_q        <= '0;
      crc_q        <= 32'hFFFFFFFF;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      rx_dv_prev_q <= 1'b0;
      idx_q        <= '0;
      last_q       <= '0;
      p_srdy_q     <= 1'b0;
      p_eop_q      <= 1'b0;
      p_status_q   <= 2'd0;
      p_len_q      <= 16'd0;
      frame_cnt_q  <= 16'd0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      rx_dv_prev_q <= rx_dv;
      idx_q        <= idx_d;
      last_q       <= last_d;
      p_srdy_q     <= p_srdy_d;
      p_eop_q      <= p_eop_d;
      p_status_q   <= p_status_d;
      p_len_q      <= p_len_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Frame buffer write port.
  always_ff @(posedge rx_clk) begin
    if (wr_en) frame_mem[wr_addr] <= rxd;
  end

  // Registered buffer read; holds while the stream is stalled.
  always_ff @(posedge rx_clk) begin
    if (reset)      p_data_q <= 8'h00;
    else if (rd_en) p_data_q <= frame_mem[rd_addr];
  end

  assign p_srdy    = p_srdy_q;
  assign p_data    = p_data_q;
  assign p_eop     = p_eop_q;
  assign p_status  = p_status_q;
  assign p_len     = p_len_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_receiver.sv
// tb_gmii_receiver: directed and randomized frames against a frame-level model.
module tb_gmii_receiver;

  localparam int MAX_LEN = 2048;
  localparam int MIN_LEN = 64;

  logic        rx_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  rxd    = 8'h00;
  logic        rx_dv  = 1'b0;
  logic        rx_er  = 1'b0;
  logic        p_drdy = 1'b0;
  logic        p_srdy;
  logic [7:0]  p_data;
  logic        p_eop;
  logic [1:0]  p_status;
  logic [15:0] p_len;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  gmii_receiver #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .rx_clk(rx_clk), .reset(reset), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop),
    .p_status(p_status), .p_len(p_len), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  initial forever #5 rx_clk = ~rx_clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Model state
  logic [7:0] wire_q[$];
  logic [7:0] body_q[$];
  logic [7:0] calc_q[$];
  logic [7:0] exp_data_q[$];
  int         exp_len_q[$];
  int         exp_stat_q[$];
  int         exp_frames = 0;
  int         exp_drops  = 0;
  int         drdy_mode  = 0;

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 never.
  initial forever begin
    @(posedge rx_clk); #1;
    case (drdy_mode)
      0:       p_drdy = 1'b1;
      1:       p_drdy = ~p_drdy;
      2:       p_drdy = ($urandom_range(0, 9) < 7);
      default: p_drdy = 1'b0;
    endcase
  end

  // Standard Ethernet CRC-32 (with final inversion) over calc_q[0..n-1].
  function automatic logic [31:0] crc32_calc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, calc_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int pre_len, input int body_len, input bit rand_body, input bit bad_fcs);
    logic [31:0] fcs;
    wire_q.delete();
    body_q.delete();
    repeat (pre_len) wire_q.push_back(8'h55);
    wire_q.push_back(8'hD5);
    for (int i = 0; i < body_len; i++) body_q.push_back(rand_body ? 8'($urandom) : 8'(i));
    calc_q = body_q;
    fcs = crc32_calc(body_len);
    if (bad_fcs) fcs[31:24] = fcs[31:24] ^ 8'h01;
    foreach (body_q[i]) wire_q.push_back(body_q[i]);
    for (int k = 0; k < 4; k++) wire_q.push_back(fcs[8*k +: 8]);
  endtask

  // Decide the fate of the burst in wire_q from the receive rules.
  task automatic predict(input int er_idx, input bit busy);
    int idx, n, stored, st;
    bit ovf, er, crc_ok;
    logic [31:0] fcs_rx;
    idx = 0;
    while (idx < wire_q.size() && wire_q[idx] == 8'h55) idx++;
    if (busy || idx >= wire_q.size() || wire_q[idx] != 8'hD5) begin
      exp_drops++;
      return;
    end
    n = wire_q.size() - idx - 1;
    if (n <= 4) begin
      exp_drops++;
      return;
    end
    calc_q.delete();
    for (int i = idx + 1; i < wire_q.size(); i++) calc_q.push_back(wire_q[i]);
    fcs_rx = {calc_q[n-1], calc_q[n-2], calc_q[n-3], calc_q[n-4]};
    crc_ok = (crc32_calc(n - 4) == fcs_rx);
    ovf    = (n > MAX_LEN);
    stored = ovf ? MAX_LEN : n;
    er     = (er_idx > idx) && (er_idx < wire_q.size());
    if (ovf || er)         st = 3;
    else if (n < MIN_LEN)  st = 2;
    else if (!crc_ok)      st = 1;
    else                   st = 0;
    for (int i = 0; i < stored - 4; i++) exp_data_q.push_back(calc_q[i]);
    exp_len_q.push_back(stored - 4);
    exp_stat_q.push_back(st);
    exp_frames++;
  endtask

  task automatic send_wire(input int er_idx);
    foreach (wire_q[i]) begin
      @(posedge rx_clk); #1;
      rx_dv = 1'b1;
      rxd   = wire_q[i];
      rx_er = (i == er_idx);
    end
    @(posedge rx_clk); #1;
    rx_dv = 1'b0;
    rxd   = 8'h00;
    rx_er = 1'b0;
  endtask

  task automatic wait_drained();
    int cyc;
    cyc = 0;
    while (exp_len_q.size() != 0 && cyc < 20000) begin
      @(posedge rx_clk);
      cyc++;
    end
    check_val("drain_done", exp_len_q.size(), 0);
    repeat (3) @(posedge rx_clk);
    #1;
  endtask

  task automatic check_counters();
    check_val("frame_cnt", frame_cnt, exp_frames);
    check_val("drop_cnt", drop_cnt, exp_drops);
  endtask

  task automatic run_frame(input int er_idx);
    predict(er_idx, 1'b0);
    send_wire(er_idx);
    wait_drained();
    check_counters();
  endtask

  // Output monitor: samples on the falling edge; a transfer happens at the next rising edge.
  int         mon_idx = 0;
  int         frames_seen = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_eop;
  initial forever begin
    @(negedge rx_clk);
    if (reset) begin
      prev_stall = 1'b0;
      mon_idx    = 0;
    end else begin
      if (prev_stall) begin
        check_val("hold_srdy", p_srdy, 1);
        check_val("hold_data", p_data, prev_data);
        check_val("hold_eop", p_eop, prev_eop);
      end
      if (p_srdy && p_drdy) begin
        if (exp_len_q.size() == 0) begin
          check_val("unexpected_byte", 1, 0);
        end else begin
          if (exp_data_q.size() != 0) check_val("data", p_data, exp_data_q.pop_front());
          check_val("eop", p_eop, (mon_idx == exp_len_q[0] - 1));
          if (p_eop) begin
            check_val("len", p_len, exp_len_q[0]);
            check_val("status", p_status, exp_stat_q[0]);
            for (int r = mon_idx + 1; r < exp_len_q[0]; r++)
              if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
            frames_seen++;
            $display("frame %0d delivered: len=%0d status=%0d", frames_seen, p_len, p_status);
            void'(exp_len_q.pop_front());
            void'(exp_stat_q.pop_front());
            mon_idx = 0;
          end else if (mon_idx == exp_len_q[0] - 1) begin
            void'(exp_len_q.pop_front());
            void'(exp_stat_q.pop_front());
            mon_idx = 0;
          end else begin
            mon_idx++;
          end
        end
      end
      prev_stall = p_srdy && !p_drdy;
      prev_data  = p_data;
      prev_eop   = p_eop;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, kind, blen, er;

    // Reset values
    repeat (3) @(posedge rx_clk);
    #1;
    check_val("rst_srdy", p_srdy, 0);
    check_val("rst_eop", p_eop, 0);
    check_val("rst_data", p_data, 0);
    check_val("rst_status", p_status, 0);
    check_val("rst_len", p_len, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    drdy_mode = 0;
    repeat (2) @(posedge rx_clk);
    #1;

    // Minimum-length good frame, with first-byte latency
    make_frame(7, 60, 1'b0, 1'b0);
    predict(-1, 1'b0);
    send_wire(-1);
    @(negedge rx_clk);
    check_val("srdy_at_n", p_srdy, 0);
    @(posedge rx_clk); #1;
    check_val("srdy_at_n1", p_srdy, 1);
    check_val("byte0_at_n1", p_data, 8'h00);
    wait_drained();
    check_counters();

    // Same frame, corrupted FCS
    make_frame(7, 60, 1'b0, 1'b1);
    run_frame(-1);

    // 20 bytes after SFD: runt
    make_frame(7, 16, 1'b1, 1'b0);
    run_frame(-1);

    // Preamble 0x55,0x57
    make_frame(7, 60, 1'b1, 1'b0);
    wire_q[1] = 8'h57;
    run_frame(-1);

    // Three bytes after SFD
    make_frame(7, 0, 1'b0, 1'b0);
    void'(wire_q.pop_back());
    run_frame(-1);

    // Back-to-back: second frame lands during drain
    drdy_mode = 1;
    make_frame(7, 60, 1'b1, 1'b0);
    predict(-1, 1'b0);
    send_wire(-1);
    make_frame(7, 20, 1'b1, 1'b0);
    predict(-1, 1'b1);
    send_wire(-1);
    wait_drained();
    check_counters();
    make_frame(7, 60, 1'b1, 1'b0);
    run_frame(-1);

    // Overflow and rx_er
    drdy_mode = 0;
    make_frame(7, MAX_LEN + 10 - 4, 1'b1, 1'b0);
    run_frame(-1);
    make_frame(7, 100, 1'b1, 1'b0);
    run_frame(8 + 50);

    // Randomized frames
    for (int t = 0; t < 24; t++) begin
      pre  = $urandom_range(0, 7);
      kind = $urandom_range(0, 9);
      if (kind == 0)     blen = $urandom_range(0, 3);
      else if (kind < 3) blen = $urandom_range(1, 59);
      else               blen = $urandom_range(60, 300);
      make_frame(pre, blen, 1'b1, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0) wire_q[$urandom_range(0, pre)] = 8'h5A;
      er = ($urandom_range(0, 7) == 0) ? (pre + 1 + $urandom_range(0, blen + 3)) : -1;
      drdy_mode = $urandom_range(0, 2);
      run_frame(er);
    end

    // Reset in the middle of a drain
    drdy_mode = 0;
    make_frame(7, 100, 1'b1, 1'b0);
    predict(-1, 1'b0);
    send_wire(-1);
    repeat (10) @(posedge rx_clk);
    #1;
    reset = 1'b1;
    @(posedge rx_clk); #1;
    check_val("mid_rst_srdy", p_srdy, 0);
    check_val("mid_rst_eop", p_eop, 0);
    check_val("mid_rst_data", p_data, 0);
    check_val("mid_rst_frame_cnt", frame_cnt, 0);
    check_val("mid_rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    exp_data_q.delete();
    exp_len_q.delete();
    exp_stat_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    repeat (2) @(posedge rx_clk);
    #1;
    make_frame(7, 64, 1'b1, 1'b0);
    run_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
